matmul_seq: RTL and testbench

Sequential, parametrised fixed-point matrix multiplier for the neural-net datapath. It computes O = A×B, adds an optional bias and applies an optional ReLU, using one multiply-accumulate per clock. It sits between the weight/activation buffers and the next layer, with the same start/done control style as the existing matmul. It adds bias, activation and saturation handling, and it accepts arbitrary element width and fractional format.

---
 rtl/matmul_seq.sv | 175 +++++++++++++++++
 tb/tb_matmul_seq.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/matmul_seq.sv
// matmul_seq: sequential fixed-point matrix multiplier O = A*B (+bias, ReLU, saturation),
// one multiply-accumulate per clock with start/busy/done handshake.
`default_nettype none

module matmul_seq #(
  parameter int S = 32,
  parameter int F = 16,
  parameter int H = 4,
  parameter int W = 1,
  parameter int C = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [H*C*S-1:0] a,
  input  logic [C*W*S-1:0] b,
  input  logic [H*W*S-1:0] bias,
  input  logic             bias_en,
  input  logic             relu_en,
  output logic [H*W*S-1:0] o,
  output logic             busy,
  output logic             done,
  output logic             ovf
);

  localparam int IW = (H > 1) ? $clog2(H) : 1;
  localparam int JW = (W > 1) ? $clog2(W) : 1;
  localparam int KW = (C > 1) ? $clog2(C) : 1;
  localparam int AW = 2*S + $clog2(C) + 1;
  // One extra bit so adding the shifted bias to a full-range accumulator cannot wrap.
  localparam int FW = AW + 1;

  localparam logic [IW-1:0] c_ilast = IW'(H-1);
  localparam logic [JW-1:0] c_jlast = JW'(W-1);
  localparam logic [KW-1:0] c_klast = KW'(C-1);

  typedef enum logic [1:0] {ST_IDLE, ST_MAC, ST_WB, ST_DONE} state_t;

  state_t                r_state;
  logic [H*C*S-1:0]      r_a;
  logic [C*W*S-1:0]      r_b;
  logic [H*W*S-1:0]      r_bias;
  logic                  r_bias_en;
  logic                  r_relu_en;
  logic [IW-1:0]         r_i;
  logic [JW-1:0]         r_j;
  logic [KW-1:0]         r_k;
  logic signed [AW-1:0]  r_acc;
  logic signed [S-1:0]   r_o [H][W];
  logic                  r_busy;
  logic                  r_done;
  logic                  r_ovf;

  logic signed [S-1:0]   w_a    [H][C];
  logic signed [S-1:0]   w_b    [C][W];
  logic signed [S-1:0]   w_bias [H][W];

  genvar gi, gj;
  generate
    for (gi = 0; gi < H; gi++) begin : g_a_row
      for (gj = 0; gj < C; gj++) begin : g_a_col
        assign w_a[gi][gj] = r_a[(H*C-(gi*C+gj))*S-1 -: S];
      end
    end
    for (gi = 0; gi < C; gi++) begin : g_b_row
      for (gj = 0; gj < W; gj++) begin : g_b_col
        assign w_b[gi][gj] = r_b[(C*W-(gi*W+gj))*S-1 -: S];
      end
    end
    for (gi = 0; gi < H; gi++) begin : g_o_row
      for (gj = 0; gj < W; gj++) begin : g_o_col
        assign w_bias[gi][gj] = r_bias[(H*W-(gi*W+gj))*S-1 -: S];
        assign o[(H*W-(gi*W+gj))*S-1 -: S] = r_o[gi][gj];
      end
    end
  endgenerate

  logic signed [2*S-1:0] w_prod;
  logic signed [AW-1:0]  w_acc_next;
  logic signed [FW-1:0]  w_bias_ext;
  logic signed [FW-1:0]  w_sum;
  logic signed [FW-1:0]  w_shr;
  logic                  w_in_range;
  logic signed [S-1:0]   w_sat;
  logic signed [S-1:0]   w_fin;

  assign w_prod     = (2*S)'(w_a[r_i][r_k]) * (2*S)'(w_b[r_k][r_j]);
  assign w_acc_next = r_acc + AW'(w_prod);
  assign w_bias_ext = FW'(w_bias[r_i][r_j]) <<< F;
  assign w_sum      = FW'(r_acc) + (r_bias_en ? w_bias_ext : '0);
  assign w_shr      = w_sum >>> F;
  // In range when every bit from the S-bit sign position upward agrees.
  assign w_in_range = (&w_shr[FW-1:S-1]) | ~(|w_shr[FW-1:S-1]);
  assign w_sat      = w_in_range ? w_shr[S-1:0]
                    : (w_shr[FW-1] ? {1'b1, {(S-1){1'b0}}} : {1'b0, {(S-1){1'b1}}});
  assign w_fin      = (r_relu_en && w_sat[S-1]) ? '0 : w_sat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_bias    <= '0;
      r_bias_en <= 1'b0;
      r_relu_en <= 1'b0;
      r_i       <= '0;
      r_j       <= '0;
      r_k       <= '0;
      r_acc     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_ovf     <= 1'b0;
      for (int i = 0; i < H; i++)
        for (int j = 0; j < W; j++)
          r_o[i][j] <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_a       <= a;
            r_b       <= b;
            r_bias    <= bias;
            r_bias_en <= bias_en;
            r_relu_en <= relu_en;
            r_i       <= '0;
            r_j       <= '0;
            r_k       <= '0;
            r_acc     <= '0;
            r_ovf     <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= ST_MAC;
          end
        end
        ST_MAC: begin
          r_acc <= w_acc_next;
          if (r_k == c_klast) begin
            r_k     <= '0;
            r_state <= ST_WB;
          end else begin
            r_k <= r_k + KW'(1);
          end
        end
        ST_WB: begin
          r_o[r_i][r_j] <= w_fin;
          r_acc         <= '0;
          if (!w_in_range) r_ovf <= 1'b1;
          if (r_i == c_ilast && r_j == c_jlast) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            if (r_j == c_jlast) begin
              r_j <= '0;
              r_i <= r_i + IW'(1);
            end else begin
              r_j <= r_j + JW'(1);
            end
            r_state <= ST_MAC;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign ovf  = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_matmul_seq.sv
// tb_matmul_seq: directed self-checking bench for matmul_seq with S=16, F=8, H=W=C=2.
`default_nettype none

module tb_matmul_seq;

  localparam int S = 16;
  localparam int F = 8;
  localparam int H = 2;
  localparam int W = 2;
  localparam int C = 2;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [H*C*S-1:0] a;
  logic [C*W*S-1:0] b;
  logic [H*W*S-1:0] bias;
  logic             bias_en;
  logic             relu_en;
  logic [H*W*S-1:0] o;
  logic             busy;
  logic             done;
  logic             ovf;

  int n_assert = 0;
  int n_fail   = 0;
  int lat;
  int bcnt;

  matmul_seq #(.S(S), .F(F), .H(H), .W(W), .C(C)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .bias    (bias),
    .bias_en (bias_en),
    .relu_en (relu_en),
    .o       (o),
    .busy    (busy),
    .done    (done),
    .ovf     (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Waits for done with a bound; optionally re-pulses start or scrambles inputs mid-run.
  task automatic wait_done(input int pulse_at, input int chg_at);
    lat  = 0;
    bcnt = busy ? 1 : 0;
    while (!done && lat < 40) begin
      if (lat == pulse_at) start = 1'b1;
      if (lat == chg_at) begin
        a    = ~a;
        b    = ~b;
        bias = ~bias;
      end
      @(posedge clk); #1;
      start = 1'b0;
      lat++;
      if (busy) bcnt++;
    end
  endtask

  task automatic run(input int pulse_at, input int chg_at);
    @(posedge clk); #1;
    chk("done_pulse", {63'b0, done}, 64'd0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(pulse_at, chg_at);
  endtask

  localparam logic [63:0] c_ident  = {16'h0100, 16'h0000, 16'h0000, 16'h0100};
  localparam logic [63:0] c_bid    = {16'h0200, 16'h0300, 16'hFF00, 16'h0080};

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    a       = '0;
    b       = '0;
    bias    = '0;
    bias_en = 1'b0;
    relu_en = 1'b0;
    #2;
    chk("rst_o",    o,               64'd0);
    chk("rst_busy", {63'b0, busy},   64'd0);
    chk("rst_done", {63'b0, done},   64'd0);
    chk("rst_ovf",  {63'b0, ovf},    64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Identity
    a = c_ident;
    b = c_bid;
    run(-1, -1);
    chk("id_o",    o,              c_bid);
    chk("id_lat",  64'(lat),       64'd12);
    chk("id_busy", 64'(bcnt),      64'd12);
    chk("id_ovf",  {63'b0, ovf},   64'd0);
    chk("id_done", {63'b0, done},  64'd1);

    // Bias / ReLU
    a = {4{16'h0100}};
    b = {16'h0100, 16'hFE00, 16'h0100, 16'hFE00};
    run(-1, -1);
    chk("nb_o", o, {16'h0200, 16'hFC00, 16'h0200, 16'hFC00});
    bias    = {4{16'h0080}};
    bias_en = 1'b1;
    relu_en = 1'b1;
    run(-1, -1);
    chk("br_o", o, {16'h0280, 16'h0000, 16'h0280, 16'h0000});
    bias_en = 1'b0;
    relu_en = 1'b0;
    bias    = '0;

    // Saturation
    a = {4{16'h7F00}};
    b = {4{16'h7F00}};
    run(-1, -1);
    chk("satp_o",   o,            {4{16'h7FFF}});
    chk("satp_ovf", {63'b0, ovf}, 64'd1);
    a = {4{16'h8000}};
    run(-1, -1);
    chk("satn_o",   o,            {4{16'h8000}});
    chk("satn_ovf", {63'b0, ovf}, 64'd1);
    a = c_ident;
    b = c_bid;
    run(-1, -1);
    chk("clr_ovf",  {63'b0, ovf}, 64'd0);
    chk("clr_o",    o,            c_bid);

    // Truncation toward -inf
    a = {16'h0001, 16'h0000, 16'h0000, 16'h0000};
    b = {16'h0080, 16'h0000, 16'h0000, 16'h0000};
    run(-1, -1);
    chk("trp_o", o, 64'd0);
    a = {16'hFFFF, 16'h0000, 16'h0000, 16'h0000};
    run(-1, -1);
    chk("trn_o", o, {16'hFFFF, 16'h0000, 16'h0000, 16'h0000});

    // Start re-pulsed mid-run
    a = {4{16'h0100}};
    b = {16'h0100, 16'hFE00, 16'h0100, 16'hFE00};
    run(4, -1);
    chk("rs_o",   o,        {16'h0200, 16'hFC00, 16'h0200, 16'hFC00});
    chk("rs_lat", 64'(lat), 64'd12);

    // Inputs changed after start
    a = c_ident;
    b = c_bid;
    run(-1, 3);
    chk("chg_o",   o,        c_bid);
    chk("chg_lat", 64'(lat), 64'd12);

    // Reset mid-run
    a = {4{16'h7F00}};
    b = {4{16'h7F00}};
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    chk("prerst_ovf",  {63'b0, ovf},  64'd1);
    chk("prerst_busy", {63'b0, busy}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mrst_o",    o,             64'd0);
    chk("mrst_busy", {63'b0, busy}, 64'd0);
    chk("mrst_done", {63'b0, done}, 64'd0);
    chk("mrst_ovf",  {63'b0, ovf},  64'd0);
    rst_n = 1'b1;
    a     = c_ident;
    b     = c_bid;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("post_busy", {63'b0, busy}, 64'd1);
    wait_done(-1, -1);
    chk("post_o",   o,            c_bid);
    chk("post_lat", 64'(lat),     64'd12);
    chk("post_ovf", {63'b0, ovf}, 64'd0);
    @(posedge clk); #1;
    chk("post_done_clr", {63'b0, done}, 64'd0);
    chk("post_hold",     o,             c_bid);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
